rvfi_bus_responder: RTL and testbench

//  Parametrised formal/sim bus responder standing in for instruction or data memory behind a core under rvfi check.

---
 rtl/rvfi_bus_responder.sv | 208 ++++++++++++++++++++
 tb/tb_rvfi_bus_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_bus_responder.sv
// ---------------------------------------------------------------------------
// rvfi_bus_responder
//
// Bus responder standing in for instruction or data memory behind a core that
// is being checked through RVFI. Requests are accepted under a free-running
// random ready, outstanding requests are tracked in order in a small tag FIFO,
// and responses come back in order with random data and random but bounded
// latency. Optional fairness forcing bounds how long a request can be stalled
// and how long the head entry can wait. A sticky flag reports core-side
// handshake violations (a refused request that is dropped or changed).
//
// Ports
//   clock           single clock, rising edge
//   reset           synchronous, active-high
//   req_valid       core request valid
//   req_ready       request accepted this cycle (combinational)
//   req_wr          1 = write
//   req_addr        request address (stability monitoring only)
//   req_size        0=byte 1=half 2=word (stability monitoring only)
//   req_data        write data (stability monitoring only)
//   rsp_valid       response valid, no back-pressure
//   rsp_wr          response belongs to a write (only when WRITE_RSP=1)
//   rsp_data        read data = rand_rsp_data; zero for write responses
//   rand_req_ready  free random ready from the harness
//   rand_rsp_valid  free random response strobe from the harness
//   rand_rsp_data   free random response data from the harness
//   outstanding     number of queued entries
//   stall_forced    ready was forced by fairness this cycle
//   proto_err       sticky core handshake violation
// ---------------------------------------------------------------------------
module rvfi_bus_responder #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int WRITE_RSP       = 0,
    parameter int FAIR            = 1,
    parameter int MAX_REQ_STALL   = 3,
    parameter int MAX_RSP_DELAY   = 3,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic              rsp_wr,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rand_req_ready,
    input  logic              rand_rsp_valid,
    input  logic [DATA_W-1:0] rand_rsp_data,
    output logic [OUT_W-1:0]  outstanding,
    output logic              stall_forced,
    output logic              proto_err
);

    localparam int   PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int   SC_W   = (MAX_REQ_STALL > 0) ? $clog2(MAX_REQ_STALL + 1) : 1;
    localparam int   HA_W   = (MAX_RSP_DELAY > 0) ? $clog2(MAX_RSP_DELAY + 1) : 1;
    localparam logic FAIR_EN = (FAIR != 0);
    localparam logic WR_EN   = (WRITE_RSP != 0);

    // Registered state
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic              tag_q [MAX_OUTSTANDING];
    logic              tag_d [MAX_OUTSTANDING];
    logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [HA_W-1:0]   head_age_q, head_age_d;
    logic              proto_err_q, proto_err_d;
    logic              prev_refused_q, prev_refused_d;
    logic              held_wr_q, held_wr_d;
    logic [ADDR_W-1:0] held_addr_q, held_addr_d;
    logic [1:0]        held_size_q, held_size_d;
    logic [DATA_W-1:0] held_data_q, held_data_d;

    // Combinational helpers
    logic full;
    logic not_empty;
    logic force_rdy;
    logic force_rsp;
    logic ready_int;
    logic rsp_int;
    logic rsp_wr_int;
    logic push;
    logic pop;
    logic violation;

    // Handshake decisions. Outputs are held low while reset is asserted so the
    // responder presents a quiet bus during reset. The occupancy used here is
    // the registered count, so a pop in this cycle never frees a slot for a
    // same-cycle push, and a freshly pushed entry can only answer next cycle.
    always_comb begin
        full       = (outstanding_q == OUT_W'(MAX_OUTSTANDING));
        not_empty  = (outstanding_q != '0);
        force_rdy  = FAIR_EN && (stall_cnt_q == SC_W'(MAX_REQ_STALL));
        force_rsp  = FAIR_EN && not_empty && (head_age_q == HA_W'(MAX_RSP_DELAY));
        ready_int  = !reset && req_valid && !full && (rand_req_ready || force_rdy);
        rsp_int    = !reset && not_empty && (rand_rsp_valid || force_rsp);
        rsp_wr_int = rsp_int && WR_EN && tag_q[rd_ptr_q];
        push       = ready_int && (!req_wr || WR_EN);
        pop        = rsp_int;
    end

    // Tag FIFO bookkeeping. Writes only enter the FIFO when they owe a
    // response; otherwise they retire at acceptance.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q;
        tag_d         = tag_q;
        if (push) begin
            tag_d[wr_ptr_q] = req_wr;
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (pop && !push) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end
    end

    // Fairness counters. The stall counter tracks consecutive refused cycles;
    // the head age tracks how long the current head entry has been waiting.
    // Both keep counting with fairness disabled, they just never force.
    always_comb begin
        stall_cnt_d = '0;
        head_age_d  = '0;
        if (req_valid && !ready_int) begin
            stall_cnt_d = (stall_cnt_q == SC_W'(MAX_REQ_STALL)) ? stall_cnt_q
                                                                : stall_cnt_q + SC_W'(1);
        end
        if (!pop && not_empty) begin
            head_age_d = (head_age_q == HA_W'(MAX_RSP_DELAY)) ? head_age_q
                                                              : head_age_q + HA_W'(1);
        end
    end

    // Handshake monitor: a request refused last cycle must still be valid and
    // unchanged this cycle. The held copy is simply last cycle's request.
    always_comb begin
        violation = prev_refused_q &&
                    (!req_valid ||
                     (req_wr   != held_wr_q)   ||
                     (req_addr != held_addr_q) ||
                     (req_size != held_size_q) ||
                     (req_data != held_data_q));
        proto_err_d    = proto_err_q || violation;
        prev_refused_d = req_valid && !ready_int;
        held_wr_d      = req_wr;
        held_addr_d    = req_addr;
        held_size_d    = req_size;
        held_data_d    = req_data;
    end

    // State registers with synchronous reset. Clearing the pointers and the
    // count drops any in-flight entries without answering them.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            outstanding_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_q[i] <= 1'b0;
            end
            stall_cnt_q    <= '0;
            head_age_q     <= '0;
            proto_err_q    <= 1'b0;
            prev_refused_q <= 1'b0;
            held_wr_q      <= 1'b0;
            held_addr_q    <= '0;
            held_size_q    <= '0;
            held_data_q    <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            outstanding_q  <= outstanding_d;
            tag_q          <= tag_d;
            stall_cnt_q    <= stall_cnt_d;
            head_age_q     <= head_age_d;
            proto_err_q    <= proto_err_d;
            prev_refused_q <= prev_refused_d;
            held_wr_q      <= held_wr_d;
            held_addr_q    <= held_addr_d;
            held_size_q    <= held_size_d;
            held_data_q    <= held_data_d;
        end
    end

    // Output drive
    always_comb begin
        req_ready    = ready_int;
        rsp_valid    = rsp_int;
        rsp_wr       = rsp_wr_int;
        rsp_data     = (rsp_int && !rsp_wr_int) ? rand_rsp_data : '0;
        outstanding  = outstanding_q;
        stall_forced = force_rdy && ready_int && !rand_req_ready;
        proto_err    = proto_err_q;
    end

endmodule

// File: tb/tb_rvfi_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_rvfi_bus_responder
//
// Drives two responders from the same request stream:
//   dut0: FAIR=0, WRITE_RSP=0 (purely random timing, writes retire at accept)
//   dut1: FAIR=1, WRITE_RSP=1 (forcing enabled, writes answered)
// Each cycle both are compared against a transaction-level model built from a
// queue of outstanding tags, stall/wait counters and a proto-error flag.
// ---------------------------------------------------------------------------
module tb_rvfi_bus_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_data;
    logic        rand_req_ready;
    logic        rand_rsp_valid;
    logic [31:0] rand_rsp_data;

    logic        req_ready0, rsp_valid0, rsp_wr0, stall_forced0, proto_err0;
    logic [31:0] rsp_data0;
    logic [2:0]  outstanding0;
    logic        req_ready1, rsp_valid1, rsp_wr1, stall_forced1, proto_err1;
    logic [31:0] rsp_data1;
    logic [2:0]  outstanding1;

    int n_checks = 0;
    int n_fail   = 0;

    // Sampled DUT outputs from the most recent step
    bit          s_rdy  [2];
    bit          s_rsp  [2];
    bit          s_rspwr[2];
    bit          s_sf   [2];
    bit          s_perr [2];
    logic [31:0] s_data [2];
    int          s_out  [2];

    // Reference model state
    bit          tq0[$];
    bit          tq1[$];
    int          m_stall[2];
    int          m_age  [2];
    bit          m_perr [2];
    bit          m_pref [2];
    bit          h_wr;
    logic [31:0] h_addr;
    logic [1:0]  h_size;
    logic [31:0] h_data;
    bit          model_on = 0;

    always #5 clock = ~clock;

    rvfi_bus_responder #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .WRITE_RSP(0), .FAIR(0),
        .MAX_REQ_STALL(3), .MAX_RSP_DELAY(3)
    ) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready0), .req_wr(req_wr),
        .req_addr(req_addr), .req_size(req_size), .req_data(req_data),
        .rsp_valid(rsp_valid0), .rsp_wr(rsp_wr0), .rsp_data(rsp_data0),
        .rand_req_ready(rand_req_ready), .rand_rsp_valid(rand_rsp_valid),
        .rand_rsp_data(rand_rsp_data), .outstanding(outstanding0),
        .stall_forced(stall_forced0), .proto_err(proto_err0)
    );

    rvfi_bus_responder #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .WRITE_RSP(1), .FAIR(1),
        .MAX_REQ_STALL(3), .MAX_RSP_DELAY(3)
    ) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready1), .req_wr(req_wr),
        .req_addr(req_addr), .req_size(req_size), .req_data(req_data),
        .rsp_valid(rsp_valid1), .rsp_wr(rsp_wr1), .rsp_data(rsp_data1),
        .rand_req_ready(rand_req_ready), .rand_rsp_valid(rand_rsp_valid),
        .rand_rsp_data(rand_rsp_data), .outstanding(outstanding1),
        .stall_forced(stall_forced1), .proto_err(proto_err1)
    );

    function automatic bit fair_of(int i);
        return (i == 1);
    endfunction

    function automatic bit wrsp_of(int i);
        return (i == 1);
    endfunction

    function automatic int qsize(int i);
        return (i == 0) ? tq0.size() : tq1.size();
    endfunction

    function automatic bit qhead(int i);
        if (i == 0) return tq0[0];
        return tq1[0];
    endfunction

    task automatic qpush(int i, bit t);
        if (i == 0) tq0.push_back(t);
        else        tq1.push_back(t);
    endtask

    task automatic qpop(int i);
        if (i == 0) void'(tq0.pop_front());
        else        void'(tq1.pop_front());
    endtask

    task automatic checkOutput(string name, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(bit v, bit wr, logic [31:0] addr, logic [1:0] size,
                                 logic [31:0] data, bit rr, bit rrv, logic [31:0] rdata);
        req_valid      = v;
        req_wr         = wr;
        req_addr       = addr;
        req_size       = size;
        req_data       = data;
        rand_req_ready = rr;
        rand_rsp_valid = rrv;
        rand_rsp_data  = rdata;
    endtask

    // One clock cycle: sample and model-check at the falling edge, then
    // advance the model across the rising edge.
    task automatic step();
        bit er[2];
        bit ev[2];
        @(negedge clock);
        s_rdy[0] = req_ready0;  s_rsp[0] = rsp_valid0;  s_rspwr[0] = rsp_wr0;
        s_sf[0]  = stall_forced0; s_perr[0] = proto_err0; s_data[0] = rsp_data0;
        s_out[0] = int'(outstanding0);
        s_rdy[1] = req_ready1;  s_rsp[1] = rsp_valid1;  s_rspwr[1] = rsp_wr1;
        s_sf[1]  = stall_forced1; s_perr[1] = proto_err1; s_data[1] = rsp_data1;
        s_out[1] = int'(outstanding1);
        for (int i = 0; i < 2; i++) begin
            int n;
            bit frdy, frsp, ewr, esf;
            logic [31:0] ed;
            n     = qsize(i);
            frdy  = fair_of(i) && (m_stall[i] == 3);
            frsp  = fair_of(i) && (n > 0) && (m_age[i] == 3);
            er[i] = !reset && req_valid && (n < 4) && (rand_req_ready || frdy);
            ev[i] = !reset && (n > 0) && (rand_rsp_valid || frsp);
            ewr   = ev[i] && wrsp_of(i) && qhead(i);
            ed    = (ev[i] && !ewr) ? rand_rsp_data : 32'h0;
            esf   = frdy && er[i] && !rand_req_ready;
            if (model_on) begin
                checkOutput($sformatf("model_req_ready%0d", i), s_rdy[i], er[i]);
                checkOutput($sformatf("model_rsp_valid%0d", i), s_rsp[i], ev[i]);
                checkOutput($sformatf("model_rsp_wr%0d", i), s_rspwr[i], ewr);
                checkOutput($sformatf("model_rsp_data%0d", i), s_data[i], ed);
                checkOutput($sformatf("model_outstanding%0d", i), s_out[i], n);
                checkOutput($sformatf("model_stall_forced%0d", i), s_sf[i], esf);
                checkOutput($sformatf("model_proto_err%0d", i), s_perr[i], m_perr[i]);
            end
        end
        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                if (i == 0) tq0.delete();
                else        tq1.delete();
                m_stall[i] = 0;
                m_age[i]   = 0;
                m_perr[i]  = 0;
                m_pref[i]  = 0;
            end else begin
                int n0;
                n0 = qsize(i);
                if (ev[i]) qpop(i);
                if (er[i] && (!req_wr || wrsp_of(i))) qpush(i, req_wr);
                m_stall[i] = (req_valid && !er[i]) ? ((m_stall[i] < 3) ? m_stall[i] + 1 : 3) : 0;
                m_age[i]   = (ev[i] || n0 == 0) ? 0 : ((m_age[i] < 3) ? m_age[i] + 1 : 3);
                if (m_pref[i] && (!req_valid || req_wr != h_wr || req_addr != h_addr ||
                                  req_size != h_size || req_data != h_data))
                    m_perr[i] = 1;
                m_pref[i] = req_valid && !er[i];
            end
        end
        h_wr = req_wr; h_addr = req_addr; h_size = req_size; h_data = req_data;
        #1;
    endtask

    task automatic applyReset(int cycles);
        applyStimulus(0, 0, 32'h0, 2'd0, 32'h0, 0, 0, 32'h0);
        reset = 1'b1;
        for (int k = 0; k < cycles; k++) step();
        reset = 1'b0;
    endtask

    typedef struct {
        bit          v;
        bit          rrv;
        logic [31:0] rdata;
        bit          e_rdy;
        bit          e_rsp;
        int          e_out;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int lat;
        int nrsp;
        int nwr;
        bit hold;

        // Fill / accept / full / pop-then-push / drain sequence for dut0
        tbl[0]  = '{1, 0, 32'h0,  1, 0, 0, 32'h0};
        tbl[1]  = '{1, 0, 32'h0,  1, 0, 1, 32'h0};
        tbl[2]  = '{1, 0, 32'h0,  1, 0, 2, 32'h0};
        tbl[3]  = '{1, 0, 32'h0,  1, 0, 3, 32'h0};
        tbl[4]  = '{1, 0, 32'h0,  0, 0, 4, 32'h0};
        tbl[5]  = '{1, 0, 32'h0,  0, 0, 4, 32'h0};
        tbl[6]  = '{1, 1, 32'hA5, 0, 1, 4, 32'hA5};
        tbl[7]  = '{1, 0, 32'h0,  1, 0, 3, 32'h0};
        tbl[8]  = '{0, 1, 32'h11, 0, 1, 4, 32'h11};
        tbl[9]  = '{0, 1, 32'h22, 0, 1, 3, 32'h22};
        tbl[10] = '{0, 1, 32'h33, 0, 1, 2, 32'h33};
        tbl[11] = '{0, 1, 32'h44, 0, 1, 1, 32'h44};
        tbl[12] = '{0, 1, 32'h55, 0, 0, 0, 32'h0};

        reset = 1'b1;
        applyReset(2);
        model_on = 1;

        // Reset state
        step();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("reset_outstanding%0d", i), s_out[i], 0);
            checkOutput($sformatf("reset_rsp_valid%0d", i), s_rsp[i], 0);
            checkOutput($sformatf("reset_proto_err%0d", i), s_perr[i], 0);
            checkOutput($sformatf("reset_req_ready%0d", i), s_rdy[i], 0);
        end

        // Table-driven fill, full hold, pop without bypass, drain
        for (int k = 0; k < 13; k++) begin
            applyStimulus(tbl[k].v, 0, 32'h100, 2'd2, 32'h0, 1, tbl[k].rrv, tbl[k].rdata);
            step();
            checkOutput($sformatf("tbl%0d_req_ready", k), s_rdy[0], tbl[k].e_rdy);
            checkOutput($sformatf("tbl%0d_rsp_valid", k), s_rsp[0], tbl[k].e_rsp);
            checkOutput($sformatf("tbl%0d_outstanding", k), s_out[0], tbl[k].e_out);
            checkOutput($sformatf("tbl%0d_rsp_data", k), s_data[0], tbl[k].e_data);
        end

        // Writes retire at acceptance when they owe no response
        applyReset(1);
        begin
            bit wseq[6];
            wseq = '{1, 0, 1, 1, 0, 1};
            for (int k = 0; k < 6; k++) begin
                applyStimulus(1, wseq[k], 32'h200 + 32'(k * 4), 2'd2, 32'(k), 1, 0, 32'h0);
                step();
                checkOutput($sformatf("wr_out_le2_%0d", k), (s_out[0] <= 2), 1);
            end
        end
        applyStimulus(0, 0, 32'h0, 2'd0, 32'h0, 1, 1, 32'hBEEF);
        nrsp = 0;
        nwr  = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) checkOutput("wr_out_after", s_out[0], 2);
            if (s_rsp[0]) nrsp++;
            if (s_rspwr[0]) nwr++;
        end
        checkOutput("wr_rsp_count", nrsp, 2);
        checkOutput("wr_rsp_wr_count", nwr, 0);

        // Forced response latency: answer 4 cycles after accept
        applyReset(1);
        applyStimulus(1, 0, 32'h300, 2'd2, 32'h0, 1, 0, 32'h0);
        step();
        checkOutput("lat_accept", s_rdy[1], 1);
        applyStimulus(0, 0, 32'h300, 2'd2, 32'h0, 0, 0, 32'h77);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (s_rsp[1] && lat == 0) lat = k;
        end
        checkOutput("lat_cycles", lat, 4);
        checkOutput("lat_out_zero", s_out[1], 0);

        // Forced ready after three refused cycles
        applyReset(1);
        applyStimulus(1, 0, 32'h400, 2'd2, 32'h0, 0, 0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            checkOutput($sformatf("stall_ready_c%0d", k), s_rdy[1], (k == 4));
            checkOutput($sformatf("stall_forced_c%0d", k), s_sf[1], (k == 4));
        end

        // Protocol violation is sticky; reset mid-flight drops the entry
        applyReset(1);
        applyStimulus(1, 0, 32'h100, 2'd2, 32'h0, 0, 0, 32'h0);
        step();
        applyStimulus(1, 0, 32'h104, 2'd2, 32'h0, 0, 0, 32'h0);
        step();
        applyStimulus(0, 0, 32'h0, 2'd0, 32'h0, 0, 0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput($sformatf("perr_sticky0_%0d", k), s_perr[0], 1);
            checkOutput($sformatf("perr_sticky1_%0d", k), s_perr[1], 1);
        end
        applyReset(1);
        applyStimulus(1, 0, 32'h500, 2'd2, 32'h0, 1, 0, 32'h0);
        step();
        applyStimulus(0, 0, 32'h0, 2'd0, 32'h0, 0, 1, 32'h99);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput($sformatf("midreset_rsp1_%0d", k), s_rsp[1], 0);
            checkOutput($sformatf("midreset_out1_%0d", k), s_out[1], 0);
            checkOutput($sformatf("midreset_perr1_%0d", k), s_perr[1], 0);
        end

        // Randomized traffic against the model
        applyReset(1);
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            bit rr, rrv;
            rr  = ($urandom_range(0, 1) == 1);
            rrv = ($urandom_range(0, 3) == 0);
            if (c % 256 == 255) begin
                applyReset(1);
                hold = 0;
            end else begin
                if (hold && ($urandom_range(0, 49) != 0)) begin
                    rand_req_ready = rr;
                    rand_rsp_valid = rrv;
                    rand_rsp_data  = $urandom;
                end else begin
                    applyStimulus(($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                                  $urandom, 2'($urandom_range(0, 2)), $urandom,
                                  rr, rrv, $urandom);
                end
                step();
                hold = req_valid && !(s_rdy[0] && s_rdy[1]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
